// File: rtl/axi_decoder.sv
// Address decoder with a single-outstanding route FSM and a built-in decode-error responder.
// The target is chosen once at decode and held until its response completes.
module axi_decoder #(
  parameter int SLAVE_NUM  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] BASE = {32'hA000_0000, 32'h8000_0000},
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] MASK = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  avalid,
  input  logic [SLAVE_NUM-1:0]  aready,
  input  logic [SLAVE_NUM-1:0]  valid,
  input  logic                  ready,
  output logic [SLAVE_NUM-1:0]  sel,
  output logic                  err_sel,
  output logic                  err_aready,
  output logic                  err_valid,
  output logic                  busy
);

  // Handshake: an address beat completes on avalid & (aready of the selected target or
  // err_aready); a response beat completes on (valid of the selected target or err_valid) & ready.
  typedef enum logic [2:0] {IDLE, ADDR, RESP, ERR_ADDR, ERR_RESP} state_t;

  state_t               state, state_next;
  logic [SLAVE_NUM-1:0] dec, sel_next;
  logic                 dec_hit, err_sel_next, launch;

  // Descending scan so the lowest-index hit overwrites any higher one.
  always_comb begin
    dec = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if ((addr & MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec    = '0;
        dec[i] = 1'b1;
      end
    end
    dec_hit = |dec;
  end

  always_comb begin
    state_next   = state;
    sel_next     = sel;
    err_sel_next = err_sel;
    launch       = 1'b0;
    case (state)
      IDLE:     launch = 1'b1;
      ADDR:     if (avalid && |(aready & sel)) state_next = RESP;
      RESP:     if (ready && |(valid & sel)) launch = 1'b1;
      ERR_ADDR: if (avalid) state_next = ERR_RESP;
      ERR_RESP: if (ready) launch = 1'b1;
      default: begin
        state_next   = IDLE;
        sel_next     = '0;
        err_sel_next = 1'b0;
      end
    endcase
    // Idle and response completion share one decode path, giving back-to-back issue.
    if (launch) begin
      if (!avalid) begin
        state_next   = IDLE;
        sel_next     = '0;
        err_sel_next = 1'b0;
      end else if (dec_hit) begin
        state_next   = ADDR;
        sel_next     = dec;
        err_sel_next = 1'b0;
      end else begin
        state_next   = ERR_ADDR;
        sel_next     = '0;
        err_sel_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      err_sel <= 1'b0;
    end else begin
      state   <= state_next;
      sel     <= sel_next;
      err_sel <= err_sel_next;
    end
  end

  assign err_aready = (state == ERR_ADDR);
  assign err_valid  = (state == ERR_RESP);
  assign busy       = (state != IDLE);

endmodule
